cam_host_seq: RTL



---
 rtl/cam_host_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cam_host_seq.sv
// Host-side command sequencer for a byte-wide CAM.
// Takes WRITE / LOOKUP / CLEAR commands, serialises them onto cam_ui as a
// header byte (plus a data byte for WRITE), then waits a bounded number of
// cycles for the CAM response strobe on cam_uo[7] and presents the result on a
// valid/ready response port.
// Optional build macro: CAM_HOST_SEQ_STATS_EN adds saturating hit/miss/error
// counters on extra output ports.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a command; cam_ui idle
// S_SEND_HDR  | header byte on cam_ui (zero for the reserved opcode)
// S_SEND_DATA | WRITE value byte on cam_ui
// S_WAIT_RSP  | watching cam_uo[7]; timer counts toward TIMEOUT
// S_RESP      | rsp_valid high until rsp_ready
module cam_host_seq #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_key,
   input  logic [3:0] cmd_val,
   output logic [7:0] cam_ui,
   input  logic [7:0] cam_uo,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_hit,
   output logic [3:0] rsp_val,
`ifdef CAM_HOST_SEQ_STATS_EN
   output logic       rsp_err,
   output logic [7:0] hit_cnt,
   output logic [7:0] miss_cnt,
   output logic [7:0] err_cnt
`else
   output logic       rsp_err
`endif
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   // Terminal count: the timer reads TIMEOUT-1 during the last allowed WAIT cycle.
   localparam logic [7:0] TIMER_TC = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_HDR,
      S_SEND_DATA,
      S_WAIT_RSP,
      S_RESP
   } state_t;

   state_t     state;
   logic [1:0] op_q;
   logic [3:0] key_q;
   logic [3:0] val_q;
   logic [7:0] timer;

   assign cmd_ready = (state == S_IDLE);

`ifdef CAM_HOST_SEQ_STATS_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction
`endif

   // Main sequencer: state, registered CAM bus, response payload and timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= 2'b00;
         key_q     <= 4'h0;
         val_q     <= 4'h0;
         timer     <= 8'h00;
         cam_ui    <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_val   <= 4'h0;
         rsp_err   <= 1'b0;
`ifdef CAM_HOST_SEQ_STATS_EN
         hit_cnt   <= 8'h00;
         miss_cnt  <= 8'h00;
         err_cnt   <= 8'h00;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               cam_ui <= 8'h00;
               if (cmd_valid) begin
                  op_q  <= cmd_op;
                  key_q <= cmd_key;
                  val_q <= cmd_val;
                  state <= S_SEND_HDR;
                  // The reserved opcode never reaches the CAM, so its header slot stays zero.
                  cam_ui <= (cmd_op == OP_RSVD) ? 8'h00 : {1'b1, cmd_op, 1'b0, cmd_key};
               end
            end

            S_SEND_HDR: begin
               if (op_q == OP_RSVD) begin
                  cam_ui    <= 8'h00;
                  rsp_valid <= 1'b1;
                  rsp_hit   <= 1'b0;
                  rsp_val   <= 4'h0;
                  rsp_err   <= 1'b1;
                  state     <= S_RESP;
`ifdef CAM_HOST_SEQ_STATS_EN
                  err_cnt   <= sat_inc(err_cnt);
`endif
               end else if (op_q == OP_WRITE) begin
                  cam_ui <= {4'b0000, val_q};
                  state  <= S_SEND_DATA;
               end else begin
                  cam_ui <= 8'h00;
                  timer  <= 8'h00;
                  state  <= S_WAIT_RSP;
               end
            end

            S_SEND_DATA: begin
               cam_ui <= 8'h00;
               timer  <= 8'h00;
               state  <= S_WAIT_RSP;
            end

            S_WAIT_RSP: begin
               cam_ui <= 8'h00;
               // A strobe on the terminal-count cycle still counts as a real response.
               if (cam_uo[7]) begin
                  rsp_valid <= 1'b1;
                  rsp_hit   <= cam_uo[6];
                  rsp_val   <= cam_uo[3:0];
                  rsp_err   <= 1'b0;
                  state     <= S_RESP;
`ifdef CAM_HOST_SEQ_STATS_EN
                  if (cam_uo[6]) hit_cnt  <= sat_inc(hit_cnt);
                  else           miss_cnt <= sat_inc(miss_cnt);
`endif
               end else if (timer == TIMER_TC) begin
                  rsp_valid <= 1'b1;
                  rsp_hit   <= 1'b0;
                  rsp_val   <= 4'h0;
                  rsp_err   <= 1'b1;
                  state     <= S_RESP;
`ifdef CAM_HOST_SEQ_STATS_EN
                  err_cnt   <= sat_inc(err_cnt);
`endif
               end else begin
                  timer <= timer + 8'd1;
               end
            end

            S_RESP: begin
               cam_ui <= 8'h00;
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               cam_ui    <= 8'h00;
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
